// File: rtl/shift_arbiter.sv
// Two-requester round-robin front end sharing one barrel shifter (SLL/SRL/SRA)
// with a one-entry output register that drains and refills on the same edge.
module shift_arbiter #(
    parameter int N = 32,
    parameter int S = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [N-1:0] req0_a,
    input  logic [S-1:0] req0_shamt,
    input  logic [1:0]   req0_op,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [N-1:0] req1_a,
    input  logic [S-1:0] req1_shamt,
    input  logic [1:0]   req1_op,

    output logic         res_valid,
    input  logic         res_ready,
    output logic [N-1:0] res_data,
    output logic         res_id,
    output logic         res_err
);

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_RSV = 2'b11
    } shift_op_e;

    logic         last_grant;
    logic         slot_open;
    logic         grant0;
    logic         grant1;
    logic         accept;
    logic [N-1:0] sel_a;
    logic [S-1:0] sel_shamt;
    shift_op_e    sel_op;
    logic [N-1:0] shift_out;
    logic         shift_err;

    // A held result that is being consumed this cycle frees the slot immediately.
    assign slot_open = !res_valid || res_ready;

    // On a tie the requester that did not win last time goes first.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    assign req0_ready = !rst && slot_open && grant0;
    assign req1_ready = !rst && slot_open && grant1;
    assign accept     = req0_ready || req1_ready;

    // Operand mux in front of the single shared shifter.
    assign sel_a     = grant1 ? req1_a     : req0_a;
    assign sel_shamt = grant1 ? req1_shamt : req0_shamt;
    assign sel_op    = shift_op_e'(grant1 ? req1_op : req0_op);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch is inferred.
        shift_out = sel_a;
        shift_err = 1'b0;
        case (sel_op)
            OP_SLL:  shift_out = sel_a << sel_shamt;
            OP_SRL:  shift_out = sel_a >> sel_shamt;
            OP_SRA:  shift_out = $signed(sel_a) >>> sel_shamt;
            default: shift_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            res_err    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            res_valid  <= 1'b1;
            res_data   <= shift_out;
            res_id     <= grant1;
            res_err    <= shift_err;
            last_grant <= grant1;
        end else if (res_ready) begin
            res_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_shift_arbiter;

    localparam int N = 32;
    localparam int S = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready;
    logic [N-1:0] req0_a;
    logic [S-1:0] req0_shamt;
    logic [1:0]   req0_op;
    logic         req1_valid, req1_ready;
    logic [N-1:0] req1_a;
    logic [S-1:0] req1_shamt;
    logic [1:0]   req1_op;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_id;
    logic         res_err;

    int checks   = 0;
    int failures = 0;

    // Behavioural model of the visible state.
    logic         m_valid;
    logic [N-1:0] m_data;
    logic         m_id;
    logic         m_err;
    logic         m_last;

    shift_arbiter #(.N(N), .S(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_shamt (req0_shamt),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_shamt (req1_shamt),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id),
        .res_err    (res_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] shift_model(input logic [N-1:0] a, input int sh, input logic [1:0] op);
        logic [N-1:0] r;
        case (op)
            2'd0: r = a << sh;
            2'd1: r = a >> sh;
            2'd2: begin
                r = a >> sh;
                if (a[N-1]) r = r | ~({N{1'b1}} >> sh);
            end
            default: r = a;
        endcase
        return r;
    endfunction

    // Returns the requester that should win this cycle, or -1 if none is valid.
    function automatic int winner();
        if (req0_valid && req1_valid) return (m_last == 1'b0) ? 1 : 0;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic slot_open_model();
        return !m_valid || res_ready;
    endfunction

    task automatic compare_outputs();
        int  w;
        logic exp_r0, exp_r1;
        w = winner();
        exp_r0 = !rst && slot_open_model() && (w == 0);
        exp_r1 = !rst && slot_open_model() && (w == 1);
        check("req0_ready", N'(req0_ready), N'(exp_r0));
        check("req1_ready", N'(req1_ready), N'(exp_r1));
        check("res_valid", N'(res_valid), N'(m_valid));
        if (m_valid) begin
            check("res_data", res_data, m_data);
            check("res_id", N'(res_id), N'(m_id));
            check("res_err", N'(res_err), N'(m_err));
        end
    endtask

    task automatic update_model();
        int w;
        w = winner();
        if (rst) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_id    = 1'b0;
            m_err   = 1'b0;
            m_last  = 1'b1;
        end else if (slot_open_model() && w >= 0) begin
            m_valid = 1'b1;
            m_id    = (w == 1);
            m_last  = (w == 1);
            if (w == 1) begin
                m_data = shift_model(req1_a, int'(req1_shamt), req1_op);
                m_err  = (req1_op == 2'b11);
            end else begin
                m_data = shift_model(req0_a, int'(req0_shamt), req0_op);
                m_err  = (req0_op == 2'b11);
            end
        end else if (m_valid && res_ready) begin
            m_valid = 1'b0;
        end
    endtask

    // One cycle: inputs were set just after a falling edge.
    task automatic tick();
        #1;
        compare_outputs();
        @(posedge clk);
        update_model();
        @(negedge clk);
    endtask

    task automatic set_req(input int idx, input logic v, input logic [N-1:0] a,
                           input logic [S-1:0] sh, input logic [1:0] op);
        if (idx == 0) begin
            req0_valid = v; req0_a = a; req0_shamt = sh; req0_op = op;
        end else begin
            req1_valid = v; req1_a = a; req1_shamt = sh; req1_op = op;
        end
    endtask

    function automatic logic [S-1:0] rand_shamt();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return S'(N - 1);
            default: return S'($urandom_range(0, N - 1));
        endcase
    endfunction

    initial begin
        m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_err = 1'b0; m_last = 1'b1;
        rst = 1'b1;
        res_ready = 1'b1;
        set_req(0, 1'b1, 32'hDEAD_BEEF, 5'd3, 2'b00);
        set_req(1, 1'b1, 32'hCAFE_F00D, 5'd3, 2'b01);
        @(negedge clk);

        // Reset: readys held low, outputs cleared.
        tick();
        tick();
        check("rst_res_valid", N'(res_valid), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_res_id", N'(res_id), 32'd0);
        check("rst_res_err", N'(res_err), 32'd0);

        // SRA sign fill.
        rst = 1'b0;
        set_req(0, 1'b1, 32'h8000_0000, 5'd4, 2'b10);
        set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
        tick();
        check("sra_valid", N'(res_valid), 32'd1);
        check("sra_data", res_data, 32'hF800_0000);
        check("sra_id", N'(res_id), 32'd0);
        check("sra_err", N'(res_err), 32'd0);

        // Shift-by-31 extremes from requester 1.
        set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
        set_req(1, 1'b1, 32'h0000_0001, 5'd31, 2'b00);
        tick();
        check("sll31_data", res_data, 32'h8000_0000);
        check("sll31_id", N'(res_id), 32'd1);
        set_req(1, 1'b1, 32'h8000_0000, 5'd31, 2'b01);
        tick();
        check("srl31_data", res_data, 32'h0000_0001);
        check("srl31_id", N'(res_id), 32'd1);

        // Reserved op passes operand through and flags an error.
        set_req(1, 1'b1, 32'h1234_5678, 5'd7, 2'b11);
        tick();
        check("rsv_data", res_data, 32'h1234_5678);
        check("rsv_err", N'(res_err), 32'd1);

        // Back-to-back alternation from reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b1, 32'h0000_00F0, 5'd1, 2'b00);
        set_req(1, 1'b1, 32'h0000_00F0, 5'd2, 2'b01);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("alt_valid", N'(res_valid), 32'd1);
            check("alt_id", N'(res_id), N'(i % 2));
        end

        // Stall: nothing accepted while the consumer is not ready.
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_id", N'(res_id), 32'd1);
            check("stall_data", res_data, 32'h0000_003C);
        end
        res_ready = 1'b1;
        tick();
        check("drain_fill_valid", N'(res_valid), 32'd1);
        check("drain_fill_id", N'(res_id), 32'd0);
        check("drain_fill_data", res_data, 32'h0000_01E0);

        // Reset while a result is held discards it and restores the tie order.
        res_ready = 1'b0;
        rst = 1'b1;
        tick();
        check("rst_hold_valid", N'(res_valid), 32'd0);
        rst = 1'b0;
        res_ready = 1'b1;
        tick();
        check("post_rst_tie_id", N'(res_id), 32'd0);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            res_ready = ($urandom_range(0, 3) != 0);
            set_req(0, ($urandom_range(0, 2) != 0), $urandom, rand_shamt(), 2'($urandom_range(0, 3)));
            set_req(1, ($urandom_range(0, 2) != 0), $urandom, rand_shamt(), 2'($urandom_range(0, 3)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
